// File: rtl/spi_slave.sv
// SPI mode-0 responder: 8-bit MSB-first frames, pins oversampled on raw_clk,
// byte-level RX/TX handshake with sticky overrun/underrun status.
module spi_slave #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] IDLE_BYTE   = 8'hff
) (
  input  logic       raw_clk,
  input  logic       reset,
  input  logic       spi_clk,
  input  logic       spi_cs,
  input  logic       spi_mosi,
  output logic       spi_miso,
  input  logic [7:0] tx_data,
  input  logic       tx_strobe,
  output logic       tx_pending,
  output logic [7:0] rx_data,
  output logic       rx_ready,
  input  logic       rx_ready_clear,
  input  logic       status_clear,
  output logic       rx_overrun,
  output logic       tx_underrun,
  output logic       busy
);

  localparam int PIN_SCLK = 0;
  localparam int PIN_CS   = 1;
  localparam int PIN_MOSI = 2;
  localparam int NUM_PINS = 3;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

  logic [NUM_PINS-1:0]    pin_raw;
  logic [NUM_PINS-1:0]    pin_sync;
  logic [SYNC_STAGES-1:0] fill_reg;

  state_t     state_reg, state_next;
  logic       sclk_prev_reg, cs_prev_reg;
  logic [2:0] bit_count_reg;
  logic [6:0] rx_shift_reg;
  logic [6:0] tx_shift_reg;
  logic [7:0] holding_reg;
  logic       pending_reg;
  logic       skip_fall_reg;
  logic       miso_reg;
  logic [7:0] rx_data_reg;
  logic       rx_ready_reg;
  logic       overrun_reg;
  logic       underrun_reg;
  logic       busy_reg;

  logic       sclk_cur, cs_cur, mosi_cur;
  logic       sclk_rise, sclk_fall, cs_fall;
  logic       shift_active, byte_done;
  logic [7:0] load_byte;

  assign pin_raw = {spi_mosi, spi_cs, spi_clk};

  generate
    for (genvar gi = 0; gi < NUM_PINS; gi++) begin : g_sync
      logic [SYNC_STAGES-1:0] chain_reg;
      always_ff @(posedge raw_clk) begin
        if (reset) chain_reg <= '0;
        else       chain_reg <= {chain_reg[SYNC_STAGES-2:0], pin_raw[gi]};
      end
      assign pin_sync[gi] = chain_reg[SYNC_STAGES-1];
    end
  endgenerate

  assign sclk_cur = pin_sync[PIN_SCLK];
  assign cs_cur   = pin_sync[PIN_CS];
  assign mosi_cur = pin_sync[PIN_MOSI];

  // CS history resets to "low", so a CS held low across reset never looks like
  // a fresh falling edge; the master must raise and drop CS again.
  assign sclk_rise    = sclk_cur & ~sclk_prev_reg;
  assign sclk_fall    = ~sclk_cur & sclk_prev_reg;
  assign cs_fall      = ~cs_cur & cs_prev_reg;
  assign shift_active = (state_reg == SHIFT) && !cs_cur;
  assign byte_done    = shift_active && sclk_rise && (bit_count_reg == 3'd7);
  assign load_byte    = pending_reg ? holding_reg : IDLE_BYTE;

  always_ff @(posedge raw_clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (cs_fall) state_next = LOAD;
      LOAD:    state_next = SHIFT;
      SHIFT:   if (byte_done) state_next = LOAD;
      default: state_next = IDLE;
    endcase
    if (cs_cur && state_reg != IDLE) state_next = IDLE;
  end

  always_ff @(posedge raw_clk) begin
    if (reset) begin
      fill_reg      <= '0;
      sclk_prev_reg <= 1'b0;
      cs_prev_reg   <= 1'b0;
      bit_count_reg <= 3'd0;
      rx_shift_reg  <= 7'd0;
      tx_shift_reg  <= 7'd0;
      holding_reg   <= 8'd0;
      pending_reg   <= 1'b0;
      skip_fall_reg <= 1'b0;
      miso_reg      <= 1'b0;
      rx_data_reg   <= 8'd0;
      rx_ready_reg  <= 1'b0;
      overrun_reg   <= 1'b0;
      underrun_reg  <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      fill_reg      <= {fill_reg[SYNC_STAGES-2:0], 1'b1};
      sclk_prev_reg <= sclk_cur;
      cs_prev_reg   <= cs_cur;
      // Only report CS once the synchronizer holds real pin samples.
      busy_reg      <= fill_reg[SYNC_STAGES-1] & ~cs_cur;

      // LOAD reads the old holding state, so a coincident strobe stays pending.
      if (tx_strobe) begin
        holding_reg <= tx_data;
        pending_reg <= 1'b1;
      end else if (state_reg == LOAD && pending_reg) begin
        pending_reg <= 1'b0;
      end

      if (state_reg == LOAD && !pending_reg) underrun_reg <= 1'b1;
      else if (status_clear)                 underrun_reg <= 1'b0;

      if (byte_done && rx_ready_reg && !rx_ready_clear) overrun_reg <= 1'b1;
      else if (status_clear)                            overrun_reg <= 1'b0;

      if (byte_done) begin
        rx_ready_reg <= 1'b1;
        rx_data_reg  <= {rx_shift_reg, mosi_cur};
      end else if (rx_ready_clear) begin
        rx_ready_reg <= 1'b0;
      end

      case (state_reg)
        IDLE: begin
          miso_reg      <= 1'b0;
          bit_count_reg <= 3'd0;
          rx_shift_reg  <= 7'd0;
          skip_fall_reg <= 1'b0;
        end
        LOAD: begin
          tx_shift_reg  <= load_byte[6:0];
          miso_reg      <= load_byte[7];
          bit_count_reg <= 3'd0;
        end
        SHIFT: begin
          if (shift_active && sclk_rise) begin
            rx_shift_reg  <= {rx_shift_reg[5:0], mosi_cur};
            bit_count_reg <= bit_count_reg + 3'd1;
          end
          // LOAD already put bit7 of the next byte on MISO, so the first fall
          // after a byte boundary must not shift it away.
          if (byte_done) begin
            skip_fall_reg <= 1'b1;
          end else if (shift_active && sclk_fall) begin
            if (skip_fall_reg) begin
              skip_fall_reg <= 1'b0;
            end else begin
              miso_reg     <= tx_shift_reg[6];
              tx_shift_reg <= {tx_shift_reg[5:0], 1'b0};
            end
          end
        end
        default: miso_reg <= 1'b0;
      endcase
    end
  end

  assign spi_miso    = miso_reg;
  assign tx_pending  = pending_reg;
  assign rx_data     = rx_data_reg;
  assign rx_ready    = rx_ready_reg;
  assign rx_overrun  = overrun_reg;
  assign tx_underrun = underrun_reg;
  assign busy        = busy_reg;

endmodule
